// File: rtl/clint_irq_seq_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// cause codes, SYSTEM instruction encodings and mstatus bit positions.
package clint_irq_seq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/clint_irq_seq.sv
// Trap sequencer: holds the pipeline, writes mepc/mcause/mstatus one per
// cycle, then pulses a redirect to mtvec (trap) or mepc (mret).
module clint_irq_seq
    import clint_irq_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              irq_i,
    input  logic              ex_jump_flag_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              busy_i,
    input  logic [ADDR_W-1:0] csr_mtvec_i,
    input  logic [ADDR_W-1:0] csr_mepc_i,
    input  logic [ADDR_W-1:0] csr_mstatus_i,
    output logic              clint_irq_flush_req_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [ADDR_W-1:0] csr_wdata_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT      = 3'd1;
    localparam logic [2:0] S_W_MEPC    = 3'd2;
    localparam logic [2:0] S_W_MCAUSE  = 3'd3;
    localparam logic [2:0] S_W_MSTATUS = 3'd4;
    localparam logic [2:0] S_M_MSTATUS = 3'd5;
    localparam logic [2:0] S_ASSERT    = 3'd6;

    logic [2:0]        r_state;
    logic              r_mret;
    logic [ADDR_W-1:0] r_cause;
    logic [ADDR_W-1:0] r_epc;

    logic              w_ecall;
    logic              w_ebreak;
    logic              w_mret;
    logic              w_irq;
    logic              w_trap;
    logic [ADDR_W-1:0] w_cause;
    logic [ADDR_W-1:0] w_epc;
    logic [ADDR_W-1:0] w_ms_entry;
    logic [ADDR_W-1:0] w_ms_exit;

    // Priority ecall > ebreak > mret > irq; the decode is mutually exclusive
    // for the instructions, so only irq needs masking by mret.
    always_comb begin
        w_ecall  = (inst_i == INST_ECALL);
        w_ebreak = (inst_i == INST_EBREAK);
        w_mret   = (inst_i == INST_MRET);
        w_irq    = irq_i & csr_mstatus_i[MSTATUS_MIE];
        w_trap   = w_ecall | w_ebreak | (w_irq & ~w_mret);
        if (w_ecall)       w_cause = ADDR_W'(CAUSE_ECALL);
        else if (w_ebreak) w_cause = ADDR_W'(CAUSE_EBREAK);
        else               w_cause = ADDR_W'(CAUSE_IRQ);
        if (w_ecall | w_ebreak || !ex_jump_flag_i) w_epc = inst_addr_i;
        else                                       w_epc = ex_jump_addr_i;
    end

    always_comb begin
        w_ms_entry               = csr_mstatus_i;
        w_ms_entry[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        w_ms_entry[MSTATUS_MIE]  = 1'b0;
        w_ms_exit                = csr_mstatus_i;
        w_ms_exit[MSTATUS_MIE]   = csr_mstatus_i[MSTATUS_MPIE];
        w_ms_exit[MSTATUS_MPIE]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mret  <= 1'b0;
            r_cause <= '0;
            r_epc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trap) begin
                        r_mret  <= 1'b0;
                        r_cause <= w_cause;
                        r_epc   <= w_epc;
                        r_state <= busy_i ? S_WAIT : S_W_MEPC;
                    end else if (w_mret) begin
                        r_mret  <= 1'b1;
                        r_state <= busy_i ? S_WAIT : S_M_MSTATUS;
                    end
                end
                S_WAIT: begin
                    if (!busy_i) r_state <= r_mret ? S_M_MSTATUS : S_W_MEPC;
                end
                S_W_MEPC:    r_state <= S_W_MCAUSE;
                S_W_MCAUSE:  r_state <= S_W_MSTATUS;
                S_W_MSTATUS: r_state <= S_ASSERT;
                S_M_MSTATUS: r_state <= S_ASSERT;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    // Detect-cycle request is gated by rst so every output reads 0 in reset.
    always_comb begin
        clint_irq_flush_req_o = (r_state != S_IDLE) | ((w_trap | w_mret) & ~rst);
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        case (r_state)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MEPC);
                csr_wdata_o = r_epc;
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MCAUSE);
                csr_wdata_o = r_cause;
            end
            S_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = w_ms_entry;
            end
            S_M_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = w_ms_exit;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = r_mret ? csr_mepc_i : csr_mtvec_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clint_irq_seq.sv
// Directed bench for clint_irq_seq: trap entry, irq, masked irq, busy stall,
// mret and mid-sequence reset, with hand-computed expected outputs.
module tb_clint_irq_seq;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, ex_jump_addr_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        irq_i, ex_jump_flag_i, busy_i;
    logic        clint_irq_flush_req_o, csr_we_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    int checks = 0;
    int errors = 0;

    clint_irq_seq dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .irq_i(irq_i),
        .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
        .busy_i(busy_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i),
        .clint_irq_flush_req_o(clint_irq_flush_req_o), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare every output against one expected vector.
    task automatic expect_out(input string tag, input logic fl, input logic we,
                              input logic [11:0] wa, input logic [31:0] wd,
                              input logic ast, input logic [31:0] aa);
        chk({tag, ".flush"}, 32'(clint_irq_flush_req_o), 32'(fl));
        chk({tag, ".we"},    32'(csr_we_o), 32'(we));
        chk({tag, ".waddr"}, 32'(csr_waddr_o), 32'(wa));
        chk({tag, ".wdata"}, csr_wdata_o, wd);
        chk({tag, ".ast"},   32'(int_assert_o), 32'(ast));
        chk({tag, ".aaddr"}, int_addr_o, aa);
    endtask

    task automatic nxt;
        @(posedge clk); #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1; inst_i = NOP; inst_addr_i = 0; irq_i = 0;
        ex_jump_flag_i = 0; ex_jump_addr_i = 0; busy_i = 0;
        csr_mtvec_i = 32'h80; csr_mepc_i = 0; csr_mstatus_i = 32'h08;
        #2;
        inst_i = 32'h0000_0073; settle;
        expect_out("rst_ecall", 0, 0, 0, 0, 0, 0);
        inst_i = NOP;
        nxt; nxt; rst = 1'b0; settle;
        expect_out("idle", 0, 0, 0, 0, 0, 0);

        // ecall at 0x100
        nxt; inst_i = 32'h0000_0073; inst_addr_i = 32'h100; settle;
        expect_out("ec.T", 1, 0, 0, 0, 0, 0);
        nxt; inst_i = NOP; settle;
        expect_out("ec.T1", 1, 1, 12'h341, 32'h100, 0, 0);
        nxt; expect_out("ec.T2", 1, 1, 12'h342, 32'd11, 0, 0);
        nxt; expect_out("ec.T3", 1, 1, 12'h300, 32'h80, 0, 0);
        nxt; expect_out("ec.T4", 1, 0, 0, 0, 1, 32'h80);
        nxt; expect_out("ec.T5", 0, 0, 0, 0, 0, 0);

        // irq with EX redirect to 0x200
        nxt; irq_i = 1; ex_jump_flag_i = 1; ex_jump_addr_i = 32'h200; inst_addr_i = 32'h300; settle;
        expect_out("irq.T", 1, 0, 0, 0, 0, 0);
        nxt; irq_i = 0; ex_jump_flag_i = 0; settle;
        expect_out("irq.T1", 1, 1, 12'h341, 32'h200, 0, 0);
        nxt; expect_out("irq.T2", 1, 1, 12'h342, 32'h8000_000B, 0, 0);
        nxt; expect_out("irq.T3", 1, 1, 12'h300, 32'h80, 0, 0);
        nxt; expect_out("irq.T4", 1, 0, 0, 0, 1, 32'h80);
        nxt; expect_out("irq.T5", 0, 0, 0, 0, 0, 0);

        // irq masked by MIE=0
        csr_mstatus_i = 32'h0; irq_i = 1; settle;
        for (int i = 0; i < 3; i++) begin
            expect_out("irqmask", 0, 0, 0, 0, 0, 0);
            nxt;
        end
        irq_i = 0; csr_mstatus_i = 32'h08;

        // ecall while busy for 3 cycles
        inst_i = 32'h0000_0073; inst_addr_i = 32'h140; busy_i = 1; settle;
        expect_out("busy.T", 1, 0, 0, 0, 0, 0);
        nxt; inst_i = NOP; settle;
        expect_out("busy.W1", 1, 0, 0, 0, 0, 0);
        nxt; expect_out("busy.W2", 1, 0, 0, 0, 0, 0);
        nxt; busy_i = 0; settle;
        expect_out("busy.W3", 1, 0, 0, 0, 0, 0);
        nxt; expect_out("busy.T4", 1, 1, 12'h341, 32'h140, 0, 0);
        nxt; busy_i = 1; settle;
        expect_out("busy.T5", 1, 1, 12'h342, 32'd11, 0, 0);
        nxt; expect_out("busy.T6", 1, 1, 12'h300, 32'h80, 0, 0);
        nxt; busy_i = 0; settle;
        expect_out("busy.T7", 1, 0, 0, 0, 1, 32'h80);
        nxt; expect_out("busy.T8", 0, 0, 0, 0, 0, 0);

        // mret, mepc 0x104, mstatus 0x80
        csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80; inst_i = 32'h3020_0073; settle;
        expect_out("mret.T", 1, 0, 0, 0, 0, 0);
        nxt; inst_i = NOP; settle;
        expect_out("mret.T1", 1, 1, 12'h300, 32'h88, 0, 0);
        nxt; expect_out("mret.T2", 1, 0, 0, 0, 1, 32'h104);
        nxt; expect_out("mret.T3", 0, 0, 0, 0, 0, 0);

        // ecall and irq together: ecall cause wins
        csr_mstatus_i = 32'h08; irq_i = 1; inst_i = 32'h0000_0073; inst_addr_i = 32'h180;
        ex_jump_flag_i = 1; ex_jump_addr_i = 32'h400; settle;
        nxt; inst_i = NOP; irq_i = 0; ex_jump_flag_i = 0; settle;
        expect_out("both.T1", 1, 1, 12'h341, 32'h180, 0, 0);
        nxt; expect_out("both.T2", 1, 1, 12'h342, 32'd11, 0, 0);

        // reset during W_MCAUSE
        rst = 1'b1; settle;
        expect_out("rstmid", 0, 0, 0, 0, 0, 0);
        nxt; rst = 1'b0; settle;
        expect_out("rstmid.R1", 0, 0, 0, 0, 0, 0);
        nxt; expect_out("rstmid.R2", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
